// File: rtl/fc_param_loader.sv
`default_nettype none
// ============================================================================
// Module      : fc_param_loader
// Description : Streams parameter words into the FC layer's weight array
//               (flat packed order), then its bias array.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_param_loader #(
    parameter int INPUT_SIZE      = 5,
    parameter int INPUT_CHANNELS  = 3,
    parameter int OUTPUT_CHANNELS = 3,
    parameter int PX_SIZE         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic [PX_SIZE-1:0]  in_data,
    output logic                in_ready,
    output logic [OUTPUT_CHANNELS-1:0][INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] weights,
    output logic [OUTPUT_CHANNELS-1:0][PX_SIZE-1:0] biases,
    output logic                busy,
    output logic                done,
    output logic                params_valid
);

    localparam int c_w_count = OUTPUT_CHANNELS * INPUT_SIZE * INPUT_SIZE * INPUT_CHANNELS;
    localparam int c_b_count = OUTPUT_CHANNELS;
    localparam int c_cnt_w   = $clog2(c_w_count + 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_load_w = 2'd1;
    localparam logic [1:0] c_st_load_b = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    logic [1:0]                       r_state;
    logic [c_cnt_w-1:0]               r_cnt;
    logic [c_w_count*PX_SIZE-1:0]     r_w;
    logic [c_b_count*PX_SIZE-1:0]     r_b;
    logic                             r_in_ready;
    logic                             r_busy;
    logic                             r_done;
    logic                             r_params_valid;
    logic                             w_xfer;

    assign w_xfer = in_valid && r_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= c_st_idle;
            r_cnt          <= '0;
            r_w            <= '0;
            r_b            <= '0;
            r_in_ready     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_params_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // start wins over any transfer presented on the same edge
            if (start) begin
                r_state        <= c_st_load_w;
                r_cnt          <= '0;
                r_in_ready     <= 1'b1;
                r_busy         <= 1'b1;
                r_params_valid <= 1'b0;
            end else begin
                case (r_state)
                    c_st_load_w: begin
                        if (w_xfer) begin
                            for (int i = 0; i < c_w_count; i++) begin
                                if (r_cnt == c_cnt_w'(i))
                                    r_w[i*PX_SIZE +: PX_SIZE] <= in_data;
                            end
                            if (r_cnt == c_cnt_w'(c_w_count - 1)) begin
                                r_state <= c_st_load_b;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    c_st_load_b: begin
                        if (w_xfer) begin
                            for (int i = 0; i < c_b_count; i++) begin
                                if (r_cnt == c_cnt_w'(i))
                                    r_b[i*PX_SIZE +: PX_SIZE] <= in_data;
                            end
                            if (r_cnt == c_cnt_w'(c_b_count - 1)) begin
                                r_state        <= c_st_done;
                                r_cnt          <= '0;
                                r_in_ready     <= 1'b0;
                                r_busy         <= 1'b0;
                                r_done         <= 1'b1;
                                r_params_valid <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign weights      = r_w;
    assign biases       = r_b;
    assign in_ready     = r_in_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign params_valid = r_params_valid;

endmodule
`default_nettype wire

// File: tb/tb_fc_param_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_param_loader
// Description : Scoreboard bench for fc_param_loader (2x2x1 input, 2 outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_param_loader;

    localparam int c_is = 2;
    localparam int c_ic = 1;
    localparam int c_oc = 2;
    localparam int c_px = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [c_px-1:0] in_data = '0;
    logic in_ready, busy, done, params_valid;
    logic [c_oc-1:0][c_is-1:0][c_is-1:0][c_ic-1:0][c_px-1:0] weights;
    logic [c_oc-1:0][c_px-1:0] biases;
    logic [63:0] w_flat;
    logic [15:0] b_flat;

    assign w_flat = weights;
    assign b_flat = biases;

    always #5 clk = ~clk;

    fc_param_loader #(
        .INPUT_SIZE(c_is), .INPUT_CHANNELS(c_ic), .OUTPUT_CHANNELS(c_oc), .PX_SIZE(c_px)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .weights(weights), .biases(biases), .busy(busy),
        .done(done), .params_valid(params_valid)
    );

    typedef struct { bit is_b; int idx; logic [7:0] val; } sb_t;
    sb_t sb[$];

    int checks = 0;
    int errors = 0;

    // reference model: 0 idle, 1 load_w, 2 load_b, 3 done
    int m_state = 0;
    int m_cnt = 0;
    logic [7:0] m_w [8];
    logic [7:0] m_b [2];
    bit m_pv = 0;
    bit m_done = 0;

    function automatic logic [3:0] ctl_exp();
        bit ld;
        ld = (m_state == 1) || (m_state == 2);
        return {ld, ld, m_done, m_pv};
    endfunction

    function automatic logic [79:0] arr_exp();
        logic [79:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = m_w[i];
        for (int i = 0; i < 2; i++) r[64 + i*8 +: 8] = m_b[i];
        return r;
    endfunction

    task automatic tick(input bit rn, input bit s, input bit v, input logic [7:0] d);
        rst_n = rn; start = s; in_valid = v; in_data = d;
        @(posedge clk);
        m_done = 0;
        if (!rn) begin
            m_state = 0; m_cnt = 0; m_pv = 0;
            for (int i = 0; i < 8; i++) m_w[i] = 8'h00;
            for (int i = 0; i < 2; i++) m_b[i] = 8'h00;
        end else if (s) begin
            m_state = 1; m_cnt = 0; m_pv = 0;
        end else if (v && m_state == 1) begin
            m_w[m_cnt] = d;
            sb.push_back('{1'b0, m_cnt, d});
            if (m_cnt == 7) begin m_state = 2; m_cnt = 0; end
            else m_cnt++;
        end else if (v && m_state == 2) begin
            m_b[m_cnt] = d;
            sb.push_back('{1'b1, m_cnt, d});
            if (m_cnt == 1) begin m_state = 3; m_cnt = 0; m_done = 1; m_pv = 1; end
            else m_cnt++;
        end
        #1;
    endtask

    // scoreboard consumer: each accepted word must be visible right after its edge
    always @(posedge clk) begin
        #2;
        while (sb.size() > 0) begin
            sb_t e;
            logic [7:0] act;
            e = sb.pop_front();
            act = e.is_b ? b_flat[e.idx*8 +: 8] : w_flat[e.idx*8 +: 8];
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL sb_%s[%0d] got %h exp %h", e.is_b ? "bias" : "weight", e.idx, act, e.val);
            end
        end
    end

    task automatic test_reset();
        tick(0, 0, 0, 8'h00);
        tick(0, 0, 0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            tick(1, 0, 1, 8'h55);
            checks++;
            if ({in_ready, busy, done, params_valid} !== 4'b0000 || {b_flat, w_flat} !== 80'h0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got ctl %b arr %h exp ctl 0000 arr 0",
                         k, {in_ready, busy, done, params_valid}, {b_flat, w_flat});
            end
        end
    endtask

    task automatic test_full_load();
        logic [7:0] words [10];
        int ndone = 0;
        for (int i = 0; i < 8; i++) words[i] = 8'(i + 1);
        words[8] = 8'hA0; words[9] = 8'hB0;
        tick(1, 1, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 1, words[i]);
            if (done) ndone++;
            checks++;
            if ({in_ready, busy, done, params_valid} !== ctl_exp()) begin
                errors++;
                $display("FAIL full_ctl word %0d got %b exp %b", i, {in_ready, busy, done, params_valid}, ctl_exp());
            end
        end
        checks++;
        if (done !== 1'b1 || params_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_done_after_last got done %b pv %b exp 1 1", done, params_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 8'h00);
            if (done) ndone++;
        end
        checks++;
        if (ndone != 1 || params_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_done_pulse got pulses %0d pv %b exp 1 1", ndone, params_valid);
        end
        checks++;
        if (weights[0][0][0][0] !== 8'h01 || weights[1][1][1][0] !== 8'h08 ||
            biases[0] !== 8'hA0 || biases[1] !== 8'hB0) begin
            errors++;
            $display("FAIL full_corners got %h %h %h %h exp 01 08 a0 b0",
                     weights[0][0][0][0], weights[1][1][1][0], biases[0], biases[1]);
        end
    endtask

    task automatic test_reload();
        logic [79:0] old_arr;
        int ndone = 0;
        old_arr = {b_flat, w_flat};
        tick(1, 1, 0, 8'h00);
        checks++;
        if (params_valid !== 1'b0 || {b_flat, w_flat} !== old_arr) begin
            errors++;
            $display("FAIL reload_start got pv %b arr %h exp pv 0 arr %h", params_valid, {b_flat, w_flat}, old_arr);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 1, 8'(8'h21 + i));
            if (done) ndone++;
            checks++;
            if ({b_flat, w_flat} !== arr_exp() || {in_ready, busy, done, params_valid} !== ctl_exp()) begin
                errors++;
                $display("FAIL reload_step %0d got arr %h ctl %b exp arr %h ctl %b", i,
                         {b_flat, w_flat}, {in_ready, busy, done, params_valid}, arr_exp(), ctl_exp());
            end
        end
        tick(1, 0, 0, 8'h00);
        checks++;
        if (ndone != 1 || done !== 1'b0 || params_valid !== 1'b1) begin
            errors++;
            $display("FAIL reload_done got pulses %0d done %b pv %b exp 1 0 1", ndone, done, params_valid);
        end
    endtask

    task automatic test_backpressure();
        int ndone = 0;
        logic [7:0] d;
        tick(1, 1, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            d = (i < 8) ? 8'(i + 1) : (i == 8 ? 8'hA0 : 8'hB0);
            tick(1, 0, 1, d);
            if (done) ndone++;
            if (i == 9) break;
            for (int g = 0; g < 3; g++) begin
                tick(1, 0, 0, 8'hEE);
                if (done) ndone++;
                checks++;
                if (busy !== 1'b1 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_stall word %0d gap %0d got busy %b rdy %b exp 1 1", i, g, busy, in_ready);
                end
            end
            checks++;
            if (ndone != 0) begin
                errors++;
                $display("FAIL bp_early_done word %0d got pulses %0d exp 0", i, ndone);
            end
        end
        tick(1, 0, 0, 8'h00);
        checks++;
        if (ndone != 1 || {b_flat, w_flat} !== 80'hB0A0_0807060504030201) begin
            errors++;
            $display("FAIL bp_final got pulses %0d arr %h exp 1 b0a00807060504030201", ndone, {b_flat, w_flat});
        end
    endtask

    task automatic test_restart();
        tick(1, 1, 0, 8'h00);
        for (int i = 0; i < 4; i++) tick(1, 0, 1, 8'(8'h41 + i));
        tick(1, 1, 1, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 1, (i < 8) ? 8'(8'h11 + i) : 8'(8'hC0 + i - 8));
            checks++;
            if (params_valid !== ((i == 9) ? 1'b1 : 1'b0) || {in_ready, busy, done, params_valid} !== ctl_exp()) begin
                errors++;
                $display("FAIL restart_ctl word %0d got %b exp %b", i, {in_ready, busy, done, params_valid}, ctl_exp());
            end
        end
        checks++;
        if ({b_flat, w_flat} !== 80'hC1C0_1817161514131211 || {b_flat, w_flat} !== arr_exp()) begin
            errors++;
            $display("FAIL restart_final got %h exp c1c01817161514131211", {b_flat, w_flat});
        end
    endtask

    task automatic test_reset_midload();
        tick(1, 1, 0, 8'h00);
        for (int i = 0; i < 5; i++) tick(1, 0, 1, 8'(8'h61 + i));
        tick(0, 0, 1, 8'h77);
        checks++;
        if ({b_flat, w_flat} !== 80'h0 || {in_ready, busy, done, params_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_clear got arr %h ctl %b exp 0 0000", {b_flat, w_flat}, {in_ready, busy, done, params_valid});
        end
        tick(1, 0, 1, 8'h77);
        checks++;
        if (in_ready !== 1'b0 || w_flat !== 64'h0) begin
            errors++;
            $display("FAIL rstmid_idle got rdy %b w %h exp 0 0", in_ready, w_flat);
        end
        tick(1, 1, 0, 8'h00);
        for (int i = 0; i < 10; i++) tick(1, 0, 1, 8'(8'h31 + i));
        checks++;
        if ({b_flat, w_flat} !== 80'h3A39_3837363534333231 || params_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_reload got arr %h pv %b exp 3a393837363534333231 1", {b_flat, w_flat}, params_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_w[i] = 8'h00;
        for (int i = 0; i < 2; i++) m_b[i] = 8'h00;
        test_reset();
        test_full_load();
        test_reload();
        test_backpressure();
        test_restart();
        test_reset_midload();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fc_param_loader.md
Name: fc_param_loader

Overview:
- Sequential writer for the fully connected layer's weight and bias arrays.
- Accepts a stream of parameter words over a valid/ready handshake, one word per transfer.
- Fills the packed weight array in flat order, then the bias array.
- Drives both arrays directly into the FC layer's weights/biases inputs and flags when a complete, coherent set is held.

Parameters:
- INPUT_SIZE, 5, input spatial size (square)
- INPUT_CHANNELS, 3, input channels per pixel
- OUTPUT_CHANNELS, 3, FC output channels
- PX_SIZE, 8, bits per parameter word
- Derived (not overridable): W_COUNT = OUTPUT_CHANNELS*INPUT_SIZE*INPUT_SIZE*INPUT_CHANNELS; B_COUNT = OUTPUT_CHANNELS; CNT_W = $clog2(W_COUNT+1)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin or restart a load
- in_valid  input  1  in_data holds a word
- in_data  input  PX_SIZE  parameter word
- in_ready  output  1  loader accepts a word this cycle
- weights  output  [OUTPUT_CHANNELS-1:0][INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0]  weight array to the FC layer
- biases  output  [OUTPUT_CHANNELS-1:0][PX_SIZE-1:0]  bias array to the FC layer
- busy  output  1  load in progress
- done  output  1  one-cycle pulse on load completion
- params_valid  output  1  arrays hold a complete set

Behaviour:
- Reset (rst_n low at clk edge):
  - State IDLE, counter 0.
  - weights and biases all zero.
  - in_ready, busy, done, params_valid all 0.
  - Reset overrides every other input, including a reset asserted mid-load.
- States: IDLE, LOAD_W, LOAD_B, DONE.
- Transfer: occurs on a clock edge where in_valid && in_ready.
- in_ready = 1 only in LOAD_W and LOAD_B. It is a registered state decode, not combinational on in_valid.
- busy = 1 in LOAD_W and LOAD_B.
- IDLE:
  - start -> LOAD_W, counter cleared to 0.
  - in_valid ignored.
- LOAD_W:
  - Transfer k (k = 0..W_COUNT-1) writes in_data into flat weight element k, with element 0 at bits [PX_SIZE-1:0] of the packed array.
  - Index order follows packing: channel-in fastest, then y, then x, then output channel slowest.
  - Counter increments per transfer.
  - The transfer with counter == W_COUNT-1 moves to LOAD_B with counter 0.
- LOAD_B:
  - Transfer k writes biases[k].
  - The transfer with counter == B_COUNT-1 moves to DONE.
- DONE:
  - done = 1 for exactly the first cycle in DONE.
  - params_valid = 1 from that same cycle and held.
  - Remains in DONE until start, which -> LOAD_W.
- Latency: a word accepted at edge N is visible on weights/biases after edge N (registered write, 1 cycle).
- Completion: done and params_valid rise the cycle after the edge that accepted the last bias.
- Start during LOAD_W/LOAD_B:
  - Restarts at LOAD_W, counter 0.
  - Any transfer on that same edge is discarded.
  - Already-written elements keep their values until overwritten.
- params_valid clears on the edge that accepts start (IDLE, DONE, or mid-load). It stays 0 until the next completion.
- Stalls: in_valid low stalls indefinitely, with no timeout and no state change.
- Words with in_ready low are not consumed; the upstream must hold them.
- Counters never exceed W_COUNT-1 / B_COUNT-1; there is no wrap into neighbouring elements.
- Unwritten array elements never change outside a transfer.

Test Plan (INPUT_SIZE=2, INPUT_CHANNELS=1, OUTPUT_CHANNELS=2, PX_SIZE=8 -> W_COUNT=8, B_COUNT=2):
1. Reset then idle:
   - Hold rst_n low 2 cycles, then in_valid=1 with no start for 5 cycles.
   - Required: in_ready=0, weights=0, biases=0, params_valid=0 throughout.
2. Full load, continuous valid:
   - start, then words 0x01..0x08 then 0xA0, 0xB0.
   - Required: weights flat element k = k+1 (weights[0][0][0][0]=0x01, weights[1][1][1][0]=0x08); biases[0]=0xA0, biases[1]=0xB0.
   - Required: done high exactly 1 cycle, one cycle after the 10th transfer; params_valid stays high after.
3. Backpressure gaps:
   - Same data as scenario 2, with in_valid low 3 cycles between every word.
   - Required: identical final arrays; busy high throughout; done appears only after the 10th accepted word.
4. Restart mid-load:
   - After 4 weights, assert start together with in_valid (word 0xFF), then send 0x11..0x18, 0xC0, 0xC1.
   - Required: 0xFF not stored; weights = 0x11..0x18; biases = 0xC0, 0xC1; params_valid 0 until completion.
5. Reload after DONE:
   - From scenario 2's end, start.
   - Required: params_valid drops next cycle; old values held until overwritten; second load completes with a new done pulse.
6. Reset mid-load:
   - rst_n low after 5 weights.
   - Required: all arrays zero, state IDLE, in_ready=0; a later start loads cleanly from element 0.
